// File: rtl/codec_reg_sequencer.sv
// Codec control-port master: streams a boot table of {addr,data} writes over a 3-wire port,
// then serves runtime single-register writes. Optional shadow readback under CFG_SHADOW_EN.
module codec_reg_sequencer #(
    parameter int NUM_REGS    = 8,
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYC     = 8,
    parameter int STARTUP_DLY = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REGS*16-1:0] init_table,
    input  logic                   reconfig,
    input  logic                   wr_valid,
    input  logic [6:0]             wr_addr,
    input  logic [8:0]             wr_data,
    output logic                   wr_ready,
`ifdef CFG_SHADOW_EN
    input  logic [6:0]             rd_addr,
    output logic [8:0]             rd_data,
`endif
    output logic                   cs,
    output logic                   spi_sck,
    output logic                   spi_mosi,
    output logic                   busy,
    output logic                   done
);
    localparam int CNT_MAX = (STARTUP_DLY > GAP_CYC)
                           ? ((STARTUP_DLY > 2*CLK_DIV) ? STARTUP_DLY : 2*CLK_DIV)
                           : ((GAP_CYC > 2*CLK_DIV) ? GAP_CYC : 2*CLK_DIV);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_DLY - 1);
    localparam logic [CW-1:0] DIV_C        = CW'(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST     = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(2*CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_REGS - 1);

    typedef enum logic [2:0] {WAIT, LOAD, SHIFT, LATCH, GAP, READY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bitn, bitn_n;
    logic [IW-1:0] idx, idx_n;
    logic          rt, rt_n;
    logic          done_n, cs_n, sck_n, mosi_n, busy_n;
    logic [15:0]   sreg, sreg_n;
    logic [15:0]   rt_word, rt_word_n;

    assign wr_ready = (state == READY) && !reconfig;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= WAIT;
            cnt      <= '0;
            bitn     <= '0;
            idx      <= '0;
            rt       <= 1'b0;
            done     <= 1'b0;
            cs       <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bitn     <= bitn_n;
            idx      <= idx_n;
            rt       <= rt_n;
            done     <= done_n;
            cs       <= cs_n;
            spi_sck  <= sck_n;
            spi_mosi <= mosi_n;
            busy     <= busy_n;
        end
    end

    always_ff @(posedge clk) begin
        sreg    <= sreg_n;
        rt_word <= rt_word_n;
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bitn_n    = bitn;
        idx_n     = idx;
        rt_n      = rt;
        done_n    = done;
        sreg_n    = sreg;
        rt_word_n = rt_word;
        case (state)
            WAIT: begin
                if (cnt == STARTUP_LAST) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                    idx_n   = '0;
                    rt_n    = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LOAD: begin
                sreg_n  = rt ? rt_word : init_table[{idx, 4'b0000} +: 16];
                state_n = SHIFT;
                cnt_n   = '0;
                bitn_n  = '0;
            end
            SHIFT: begin
                // Rotating (not shifting) leaves the word intact after 16 falling edges,
                // so it is still available in LATCH for the shadow copy.
                if (cnt == BIT_LAST) begin
                    cnt_n  = '0;
                    sreg_n = {sreg[14:0], sreg[15]};
                    bitn_n = bitn + 4'd1;
                    if (bitn == 4'd15) state_n = LATCH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LATCH: begin
                if (cnt == DIV_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (!rt && idx != IDX_LAST) begin
                        idx_n   = idx + 1'b1;
                        state_n = LOAD;
                    end else begin
                        state_n = READY;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            READY: begin
                if (reconfig) begin
                    idx_n   = '0;
                    rt_n    = 1'b0;
                    state_n = LOAD;
                end else if (wr_valid) begin
                    rt_word_n = {wr_addr, wr_data};
                    rt_n      = 1'b1;
                    state_n   = LOAD;
                end
            end
            default: state_n = WAIT;
        endcase
    end

    // Pin values are registered from the next-state view so they change with the state.
    always_comb begin
        cs_n   = !(state_n == SHIFT || state_n == LATCH);
        sck_n  = (state_n == SHIFT) && (cnt_n >= DIV_C);
        mosi_n = (state_n == SHIFT) && sreg_n[15];
        busy_n = state_n inside {LOAD, SHIFT, LATCH, GAP};
    end

`ifdef CFG_SHADOW_EN
    logic [8:0]   shadow [128];
    logic [127:0] shadow_vld;
    logic         shadow_we;

    assign shadow_we = (state == LATCH) && (cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (shadow_we) shadow[sreg[15:9]] <= sreg[8:0];
    end

    // A valid bit per address gives the cleared-on-reset view without resetting the array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_vld <= '0;
            rd_data    <= '0;
        end else begin
            if (shadow_we) shadow_vld[sreg[15:9]] <= 1'b1;
            rd_data <= shadow_vld[rd_addr] ? shadow[rd_addr] : 9'd0;
        end
    end
`endif

endmodule
